// File: rtl/i2c_slave_sensor.sv
// I2C read-only sensor responder: returns a coherent 16-bit snapshot of data_i, msb first.
// Define I2C_SLAVE_WRITE_EN to also accept writes into cfg_o.
module i2c_slave_sensor #(
   parameter logic [6:0]  SADR       = 7'h10,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_pad_i,
   input  logic        sda_pad_i,
   output logic        sda_pad_o,
   output logic        sda_padoen_o,
   input  logic [15:0] data_i,
   output logic        busy_o,
   output logic        rd_done_o,
   output logic [7:0]  cfg_o
);

`ifdef I2C_SLAVE_WRITE_EN
   localparam bit WRITE_EN = 1'b1;
`else
   localparam bit WRITE_EN = 1'b0;
`endif
   localparam int CW = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACKCHK, RX_BYTE, RX_ACK, IGNORE
   } state_t;

   // index 0 = SCL, index 1 = SDA
   logic [1:0]         sync1_q, sync2_q, filt_q, accept, rise, fall;
   logic [1:0][CW-1:0] fcnt_q;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         accept[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == CW'(FILTER_LEN - 1));
         rise[i]   = accept[i] & sync2_q[i];
         fall[i]   = accept[i] & ~sync2_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         filt_q  <= 2'b11;
         fcnt_q  <= '0;
      end else begin
         sync1_q <= {sda_pad_i, scl_pad_i};
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (accept[i]) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + CW'(1);
            end
         end
      end
   end

   logic scl_rise, scl_fall, sda_in, start_c, stop_c;
   assign scl_rise = rise[0];
   assign scl_fall = fall[0];
   assign sda_in   = filt_q[1];
   assign start_c  = fall[1] & filt_q[0];
   assign stop_c   = rise[1] & filt_q[0];

   state_t      state_q, state_d;
   logic [3:0]  bcnt_q, bcnt_d;
   logic [7:0]  shreg_q, shreg_d, tx_q, tx_d, cfg_q, cfg_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] shadow_q, shadow_d;
   logic        rw_q, rw_d, busy_q, busy_d, done_q, done_d;
   logic        oen_q, fall_d1_q, drive_low;

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
      idx_d     = idx_q;
      rw_d      = rw_q;
      shadow_d  = shadow_q;
      busy_d    = busy_q;
      cfg_d     = cfg_q;
      done_d    = 1'b0;
      drive_low = 1'b0;
      case (state_q)
         ADDR: if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_in};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == 4'd7) begin
               bcnt_d = '0;
               rw_d   = sda_in;
               if (shreg_q[6:0] == SADR && (sda_in || WRITE_EN)) begin
                  state_d  = ADDR_ACK;
                  shadow_d = data_i;
                  busy_d   = 1'b1;
               end else begin
                  state_d = IGNORE;
               end
            end
         end
         ADDR_ACK: begin
            drive_low = 1'b1;
            // bcnt marks that the 9th rise was seen, so the 8th fall does not end the ACK
            if (scl_rise) begin
               bcnt_d = 4'd1;
            end else if (scl_fall && bcnt_q == 4'd1) begin
               bcnt_d = '0;
               if (rw_q) begin
                  state_d = TX_BYTE;
                  tx_d    = shadow_q[15:8];
                  idx_d   = '0;
               end else begin
                  state_d = RX_BYTE;
               end
            end
         end
         TX_BYTE: begin
            drive_low = ~tx_q[7];
            if (scl_rise) begin
               bcnt_d = bcnt_q + 4'd1;
            end else if (scl_fall) begin
               if (bcnt_q == 4'd8) begin
                  state_d = TX_ACKCHK;
                  bcnt_d  = '0;
               end else begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         end
         TX_ACKCHK: begin
            if (scl_rise) begin
               if (sda_in) begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
                  done_d  = (idx_q == 2'd1);
               end else begin
                  bcnt_d = 4'd1;
               end
            end else if (scl_fall && bcnt_q == 4'd1) begin
               state_d = TX_BYTE;
               bcnt_d  = '0;
               tx_d    = (idx_q == 2'd0) ? shadow_q[7:0] : 8'hFF;
               idx_d   = (idx_q == 2'd2) ? 2'd2 : idx_q + 2'd1;
            end
         end
         RX_BYTE: if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_in};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == 4'd7) begin
               cfg_d   = {shreg_q[6:0], sda_in};
               state_d = RX_ACK;
               bcnt_d  = '0;
            end
         end
         RX_ACK: begin
            drive_low = 1'b1;
            if (scl_rise) begin
               bcnt_d = 4'd1;
            end else if (scl_fall && bcnt_q == 4'd1) begin
               state_d = RX_BYTE;
               bcnt_d  = '0;
            end
         end
         default: ;
      endcase
      if (start_c) begin
         state_d = ADDR;
         bcnt_d  = '0;
         busy_d  = 1'b0;
      end else if (stop_c) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         bcnt_q    <= '0;
         shreg_q   <= '0;
         tx_q      <= '0;
         idx_q     <= '0;
         rw_q      <= 1'b0;
         shadow_q  <= '0;
         busy_q    <= 1'b0;
         cfg_q     <= '0;
         done_q    <= 1'b0;
         oen_q     <= 1'b1;
         fall_d1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         idx_q     <= idx_d;
         rw_q      <= rw_d;
         shadow_q  <= shadow_d;
         busy_q    <= busy_d;
         cfg_q     <= cfg_d;
         done_q    <= done_d;
         fall_d1_q <= scl_fall;
         // SDA only moves one clock after SCL falls, except bus conditions release it at once
         if (start_c || stop_c) begin
            oen_q <= 1'b1;
         end else if (fall_d1_q) begin
            oen_q <= ~drive_low;
         end
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = oen_q;
   assign busy_o       = busy_q;
   assign rd_done_o    = done_q;
   assign cfg_o        = cfg_q;

endmodule

// File: tb/tb_i2c_slave_sensor.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA, expected read bytes via a queue.
module tb_i2c_slave_sensor;
   localparam int Q = 10;
`ifdef I2C_SLAVE_WRITE_EN
   localparam bit WR = 1'b1;
`else
   localparam bit WR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        m_scl, m_sda, sda_bus;
   logic        sda_pad_o, sda_padoen_o, busy_o, rd_done_o;
   logic [15:0] data_i;
   logic [7:0]  cfg_o;
   logic [7:0]  exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          drv_cnt = 0;

   always #5 clk = ~clk;
   assign sda_bus = m_sda & (sda_padoen_o | sda_pad_o);

   i2c_slave_sensor dut (
      .clk          (clk),
      .rst          (rst),
      .scl_pad_i    (m_scl),
      .sda_pad_i    (sda_bus),
      .sda_pad_o    (sda_pad_o),
      .sda_padoen_o (sda_padoen_o),
      .data_i       (data_i),
      .busy_o       (busy_o),
      .rd_done_o    (rd_done_o),
      .cfg_o        (cfg_o)
   );

   always @(negedge clk) begin
      if (rd_done_o) done_cnt++;
      if (!sda_padoen_o) drv_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_c;
      m_sda = 1'b1; idle(Q);
      m_scl = 1'b1; idle(2*Q);
      m_sda = 1'b0; idle(2*Q);
      m_scl = 1'b0; idle(Q);
   endtask

   task automatic stop_c;
      m_sda = 1'b0; idle(Q);
      m_scl = 1'b1; idle(2*Q);
      m_sda = 1'b1; idle(2*Q);
   endtask

   task automatic bit_c(input logic b, input bit glitch, output logic r);
      m_sda = b; idle(Q);
      m_scl = 1'b1;
      if (glitch) begin
         idle(Q/2); m_sda = ~b; idle(1); m_sda = b; idle(Q/2 - 1);
      end else begin
         idle(Q);
      end
      r = sda_bus; idle(Q);
      m_scl = 1'b0; idle(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit glitch, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_c(b[i], glitch && i == 7, r);
      bit_c(1'b1, 1'b0, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_c(1'b1, 1'b0, r);
         d[i] = r;
      end
      bit_c(~ack, 1'b0, r);
   endtask

   task automatic rd_chk(input string tag, input logic ack, input logic [7:0] exp);
      logic [7:0] got;
      exp_q.push_back(exp);
      rd_byte(ack, got);
      chk(tag, {8'h00, got}, {8'h00, exp_q.pop_front()});
   endtask

   initial begin
      logic ack;
      int   d0;
      rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1; data_i = 16'h1234;
      idle(5);
      chk("rst_oen", {15'd0, sda_padoen_o}, 16'd1);
      chk("rst_busy", {15'd0, busy_o}, 16'd0);
      chk("rst_done", {15'd0, rd_done_o}, 16'd0);
      chk("rst_cfg", {8'd0, cfg_o}, 16'h0000);
      rst = 1'b1; idle(10);

      // basic read: msb ACKed, lsb NACKed
      d0 = done_cnt;
      start_c; wr_byte(8'h21, 1'b0, ack);
      chk("t1_addr_ack", {15'd0, ack}, 16'd1);
      chk("t1_busy", {15'd0, busy_o}, 16'd1);
      rd_chk("t1_msb", 1'b1, 8'h12);
      rd_chk("t1_lsb", 1'b0, 8'h34);
      stop_c;
      chk("t1_done", 16'(done_cnt - d0), 16'd1);
      chk("t1_busy_stop", {15'd0, busy_o}, 16'd0);

      // wrong address: SDA never driven
      d0 = drv_cnt;
      start_c; wr_byte(8'h23, 1'b0, ack);
      chk("t2_nack", {15'd0, ack}, 16'd0);
      chk("t2_busy", {15'd0, busy_o}, 16'd0);
      stop_c;
      chk("t2_nodrive", 16'(drv_cnt - d0), 16'd0);

      // data_i change after snapshot only seen on the next read
      start_c; wr_byte(8'h21, 1'b0, ack);
      chk("t3_ack", {15'd0, ack}, 16'd1);
      data_i = 16'hABCD;
      rd_chk("t3_msb_old", 1'b1, 8'h12);
      rd_chk("t3_lsb_old", 1'b0, 8'h34);
      stop_c;
      start_c; wr_byte(8'h21, 1'b0, ack);
      rd_chk("t3_msb_new", 1'b1, 8'hAB);
      rd_chk("t3_lsb_new", 1'b0, 8'hCD);
      stop_c;

      // over-read pads with FF, no rd_done
      data_i = 16'h1234;
      d0 = done_cnt;
      start_c; wr_byte(8'h21, 1'b0, ack);
      rd_chk("t4_b0", 1'b1, 8'h12);
      rd_chk("t4_b1", 1'b1, 8'h34);
      rd_chk("t4_b2", 1'b1, 8'hFF);
      rd_chk("t4_b3", 1'b0, 8'hFF);
      stop_c;
      chk("t4_nodone", 16'(done_cnt - d0), 16'd0);

      // reset while slave drives a 0 data bit
      start_c; wr_byte(8'h21, 1'b0, ack);
      chk("t5_driving", {15'd0, sda_padoen_o}, 16'd0);
      rst = 1'b0; idle(1);
      chk("t5_released", {15'd0, sda_padoen_o}, 16'd1);
      chk("t5_busy", {15'd0, busy_o}, 16'd0);
      rst = 1'b1; idle(5);
      stop_c;
      start_c; wr_byte(8'h21, 1'b0, ack);
      chk("t5_re_ack", {15'd0, ack}, 16'd1);
      rd_chk("t5_msb", 1'b1, 8'h12);
      rd_chk("t5_lsb", 1'b0, 8'h34);
      stop_c;

      // write to own address
      start_c; wr_byte(8'h20, 1'b0, ack);
      chk("t6_waddr_ack", {15'd0, ack}, {15'd0, WR});
      wr_byte(8'h5A, 1'b0, ack);
      chk("t6_wdata_ack", {15'd0, ack}, {15'd0, WR});
      stop_c;
      chk("t6_cfg", {8'd0, cfg_o}, WR ? 16'h005A : 16'h0000);

      // 1-clk SDA glitch on idle bus must not look like START
      m_sda = 1'b0; idle(1); m_sda = 1'b1; idle(2*Q);
      m_scl = 1'b0; idle(Q);
      wr_byte(8'h21, 1'b0, ack);
      chk("g_no_start", {15'd0, ack}, 16'd0);
      stop_c;

      // 1-clk SDA high glitch while SCL high in a 0 address bit must not look like STOP
      start_c; wr_byte(8'h21, 1'b1, ack);
      chk("g_no_stop", {15'd0, ack}, 16'd1);
      rd_chk("g_msb", 1'b1, 8'h12);
      rd_chk("g_lsb", 1'b0, 8'h34);
      stop_c;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
